// File: rtl/acc_cpu_param_if.sv
// Fetch and data-memory bus for acc_cpu_param.
// The master side is the core and the slave side is the ROM/RAM/bus fabric.
interface acc_cpu_param_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [7+DW:0]  instr_in;
    logic           instr_valid;
    logic [AW-1:0]  pc_out;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic           mem_req;
    logic           mem_we;
    logic           mem_ack;

    modport master (
        input  instr_in, instr_valid, mem_rdata, mem_ack,
        output pc_out, mem_addr, mem_wdata, mem_req, mem_we
    );

    modport slave (
        output instr_in, instr_valid, mem_rdata, mem_ack,
        input  pc_out, mem_addr, mem_wdata, mem_req, mem_we
    );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator core: fetch/exec/mem FSM, hardware return stack,
// valid-handshaked instruction fetch and req/ack data memory.
module acc_cpu_param #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              res,
    acc_cpu_param_if.master   bus,
    output logic [DW-1:0]     ac_out,
    output logic [1:0]        flags_out,
    output logic              halted,
    output logic              stack_fault
);
    // Stack pointer must be able to hold STACK_DEPTH itself (the "full" value).
    localparam int              SPW     = $clog2(STACK_DEPTH + 1);
    localparam int              SLOTS   = 1 << SPW;
    localparam logic [SPW-1:0]  SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);
    localparam logic [AW-1:0]   PC_ONE  = AW'(1);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_ADDM = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_OR   = 8'h08;
    localparam logic [7:0] OP_XOR  = 8'h09;
    localparam logic [7:0] OP_JMP  = 8'h0A;
    localparam logic [7:0] OP_JZ   = 8'h0B;
    localparam logic [7:0] OP_JC   = 8'h0C;
    localparam logic [7:0] OP_CALL = 8'h0D;
    localparam logic [7:0] OP_RET  = 8'h0E;
    localparam logic [7:0] OP_HLT  = 8'h0F;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   pc, pc_inc;
    logic [DW-1:0]   ac;
    logic            c_flag, z_flag;
    logic [7+DW:0]   ir;
    logic [7:0]      opcode;
    logic [DW-1:0]   imm;
    logic [AW-1:0]   opa;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            we_q;
    logic [SPW-1:0]  sp, sp_dec;
    logic [AW-1:0]   stack [SLOTS];
    logic            stack_full, stack_empty, push;
    logic [DW:0]     add_imm, sub_imm, add_mem;

    assign opcode      = ir[7+DW:DW];
    assign imm         = ir[DW-1:0];
    assign opa         = imm[AW-1:0];
    assign pc_inc      = pc + PC_ONE;
    assign sp_dec      = sp - SP_ONE;
    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign push        = (state == ST_EXEC) && (opcode == OP_CALL) && !stack_full;
    // Extra top bit carries the ADD carry / SUB borrow.
    assign add_imm     = {1'b0, ac} + {1'b0, imm};
    assign sub_imm     = {1'b0, ac} - {1'b0, imm};
    assign add_mem     = {1'b0, ac} + {1'b0, bus.mem_rdata};

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= ST_FETCH;
        else      state <= state_nx;
    end

    // Next-state decode; unknown opcodes and stack faults end in HALT.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FETCH: if (bus.instr_valid) state_nx = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LD, OP_ST, OP_ADDM: state_nx = ST_MEM;
                    OP_HLT:                state_nx = ST_HALT;
                    OP_CALL:               state_nx = stack_full  ? ST_HALT : ST_FETCH;
                    OP_RET:                state_nx = stack_empty ? ST_HALT : ST_FETCH;
                    OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_JMP, OP_JZ, OP_JC:  state_nx = ST_FETCH;
                    default:               state_nx = ST_HALT;
                endcase
            end
            ST_MEM:  if (bus.mem_ack) state_nx = ST_FETCH;
            ST_HALT: state_nx = ST_HALT;
        endcase
    end

    // Outputs derived from registered state and datapath registers.
    always_comb begin
        bus.pc_out    = pc;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = we_q;
        bus.mem_req   = (state == ST_MEM);
        halted        = (state == ST_HALT);
        ac_out        = ac;
        flags_out     = {c_flag, z_flag};
    end

    // Datapath: IR latch, ALU/flags, PC sequencing, memory address/data regs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pc          <= '0;
            ac          <= '0;
            c_flag      <= 1'b0;
            z_flag      <= 1'b0;
            ir          <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sp          <= '0;
            stack_fault <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: if (bus.instr_valid) ir <= bus.instr_in;
                ST_EXEC: begin
                    case (opcode)
                        OP_NOP: pc <= pc_inc;
                        OP_LDI: begin
                            ac     <= imm;
                            z_flag <= (imm == '0);
                            pc     <= pc_inc;
                        end
                        OP_LD, OP_ADDM: begin
                            addr_q <= opa;
                            we_q   <= 1'b0;
                        end
                        OP_ST: begin
                            addr_q  <= opa;
                            we_q    <= 1'b1;
                            wdata_q <= ac;
                        end
                        OP_ADD: begin
                            ac     <= add_imm[DW-1:0];
                            c_flag <= add_imm[DW];
                            z_flag <= (add_imm[DW-1:0] == '0);
                            pc     <= pc_inc;
                        end
                        OP_SUB: begin
                            ac     <= sub_imm[DW-1:0];
                            c_flag <= sub_imm[DW];
                            z_flag <= (sub_imm[DW-1:0] == '0);
                            pc     <= pc_inc;
                        end
                        OP_AND: begin
                            ac     <= ac & imm;
                            z_flag <= ((ac & imm) == '0);
                            pc     <= pc_inc;
                        end
                        OP_OR: begin
                            ac     <= ac | imm;
                            z_flag <= ((ac | imm) == '0);
                            pc     <= pc_inc;
                        end
                        OP_XOR: begin
                            ac     <= ac ^ imm;
                            z_flag <= ((ac ^ imm) == '0);
                            pc     <= pc_inc;
                        end
                        OP_JMP: pc <= opa;
                        OP_JZ:  pc <= z_flag ? opa : pc_inc;
                        OP_JC:  pc <= c_flag ? opa : pc_inc;
                        OP_CALL: begin
                            if (stack_full) begin
                                stack_fault <= 1'b1;
                            end else begin
                                sp <= sp + SP_ONE;
                                pc <= opa;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                stack_fault <= 1'b1;
                            end else begin
                                sp <= sp_dec;
                                pc <= stack[sp_dec];
                            end
                        end
                        default: ; // HLT and illegal opcodes keep PC on the halting word
                    endcase
                end
                ST_MEM: begin
                    if (bus.mem_ack) begin
                        if (opcode == OP_LD) begin
                            ac     <= bus.mem_rdata;
                            z_flag <= (bus.mem_rdata == '0);
                        end else if (opcode == OP_ADDM) begin
                            ac     <= add_mem[DW-1:0];
                            c_flag <= add_mem[DW];
                            z_flag <= (add_mem[DW-1:0] == '0);
                        end
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Return-address storage; contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc_inc;
    end
endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: ROM/RAM models with configurable ack latency and
// a scoreboard of expected data-memory accesses.
module tb_acc_cpu_param;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int IW = 8 + DW;

    localparam logic [7:0] NOP = 8'h00, LDI = 8'h01, LD  = 8'h02, ST  = 8'h03;
    localparam logic [7:0] ADD = 8'h04, ADDM = 8'h05, SUB = 8'h06, AND_ = 8'h07;
    localparam logic [7:0] XOR_ = 8'h09, JMP = 8'h0A, JZ = 8'h0B, JC = 8'h0C;
    localparam logic [7:0] CALL = 8'h0D, RET = 8'h0E, HLT = 8'h0F;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    acc_cpu_param_if #(.DW(DW), .AW(AW)) bus ();
    logic [DW-1:0] ac_out;
    logic [1:0]    flags_out;
    logic          halted, stack_fault;

    acc_cpu_param #(.DW(DW), .AW(AW), .STACK_DEPTH(4)) dut (
        .clk(clk), .res(res), .bus(bus), .ac_out(ac_out),
        .flags_out(flags_out), .halted(halted), .stack_fault(stack_fault)
    );

    logic [IW-1:0] rom  [256];
    logic [DW-1:0] dmem [256];
    assign bus.instr_in  = rom[bus.pc_out];
    assign bus.mem_rdata = dmem[bus.mem_addr];

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;
    acc_t sb_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int ack_lat = 1;
    bit rnd_valid = 1'b0;
    int wcnt = 0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_we;
    acc_t          e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fetch valid gating, memory ack generation, hold checks and scoreboard pop.
    always @(negedge clk) begin
        bus.instr_valid = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!res) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end else if (bus.mem_ack) begin
            chk("req_drop", 32'(bus.mem_req), 0);
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end else if (bus.mem_req) begin
            wcnt++;
            if (wcnt == 1) begin
                h_addr = bus.mem_addr; h_wdata = bus.mem_wdata; h_we = bus.mem_we;
            end else begin
                chk("hold_addr",  32'(bus.mem_addr),  32'(h_addr));
                chk("hold_wdata", 32'(bus.mem_wdata), 32'(h_wdata));
                chk("hold_we",    32'(bus.mem_we),    32'(h_we));
            end
            if (wcnt >= ack_lat) begin
                bus.mem_ack = 1'b1;
                chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("acc_we",   32'(bus.mem_we),   32'(e.we));
                    chk("acc_addr", 32'(bus.mem_addr), 32'(e.addr));
                    if (e.we) chk("st_data", 32'(bus.mem_wdata), 32'(e.data));
                end
                if (bus.mem_we) dmem[bus.mem_addr] = bus.mem_wdata;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] op, input logic [7:0] imm);
        rom[a] = {op, imm};
    endtask

    task automatic sb_push(input logic we, input logic [7:0] a, input logic [7:0] d);
        acc_t x;
        x.we = we; x.addr = a; x.data = d;
        sb_q.push_back(x);
    endtask

    // Enter reset and blank the program; caller loads code then calls release_rst.
    task automatic begin_test();
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 256; i++) rom[8'(i)] = {HLT, 8'h00};
        sb_q.delete();
    endtask

    task automatic release_rst();
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
        chk("halt_reached", 32'(halted), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[8'(i)] = '0;
        begin_test();
        cycles(2);
        // reset state
        chk("rst_pc",     32'(bus.pc_out),    0);
        chk("rst_ac",     32'(ac_out),        0);
        chk("rst_flags",  32'(flags_out),     0);
        chk("rst_halted", 32'(halted),        0);
        chk("rst_fault",  32'(stack_fault),   0);
        chk("rst_req",    32'(bus.mem_req),   0);
        chk("rst_we",     32'(bus.mem_we),    0);
        chk("rst_addr",   32'(bus.mem_addr),  0);
        chk("rst_wdata",  32'(bus.mem_wdata), 0);

        // LDI F0; ADD 20 -> 0x10 with carry, two cycles each
        put(8'h00, LDI, 8'hF0); put(8'h01, ADD, 8'h20);
        release_rst();
        cycles(2);
        chk("t1_pc1",    32'(bus.pc_out), 1);
        chk("t1_ac1",    32'(ac_out), 'hF0);
        chk("t1_fl1",    32'(flags_out), 0);
        cycles(2);
        chk("t1_pc2",    32'(bus.pc_out), 2);
        chk("t1_ac2",    32'(ac_out), 'h10);
        chk("t1_fl2",    32'(flags_out), 2);
        wait_halt();
        chk("t1_hlt_pc", 32'(bus.pc_out), 2);

        // memory ops with 3-cycle ack latency
        begin_test();
        ack_lat = 3;
        dmem[8'h41] = 8'hFC;
        put(8'h00, LDI, 8'h05); put(8'h01, ST, 8'h40); put(8'h02, LDI, 8'h00);
        put(8'h03, LD, 8'h40);  put(8'h04, ADDM, 8'h41);
        sb_push(1'b1, 8'h40, 8'h05); sb_push(1'b0, 8'h40, 8'h00); sb_push(1'b0, 8'h41, 8'h00);
        release_rst();
        wait_halt();
        chk("t2_pc",    32'(bus.pc_out), 5);
        chk("t2_ac",    32'(ac_out), 'h01);
        chk("t2_flags", 32'(flags_out), 2);
        chk("t2_dmem",  32'(dmem[8'h40]), 'h05);
        chk("t2_drain", 32'(sb_q.size()), 0);
        ack_lat = 1;

        // SUB to zero, JZ, borrow, JC, logic ops preserving carry
        begin_test();
        put(8'h00, LDI, 8'h03); put(8'h01, SUB, 8'h03); put(8'h02, JZ, 8'h10);
        put(8'h10, SUB, 8'h01); put(8'h11, JC, 8'h20);
        put(8'h20, AND_, 8'h0F); put(8'h21, XOR_, 8'h0F);
        release_rst();
        cycles(4);
        chk("t3_pc_sub", 32'(bus.pc_out), 2);
        chk("t3_ac_sub", 32'(ac_out), 0);
        chk("t3_fl_sub", 32'(flags_out), 1);
        rnd_valid = 1'b1;
        wait_halt();
        rnd_valid = 1'b0;
        chk("t3_pc",    32'(bus.pc_out), 'h22);
        chk("t3_ac",    32'(ac_out), 0);
        chk("t3_flags", 32'(flags_out), 3);

        // nested CALL/RET return in LIFO order
        begin_test();
        put(8'h00, CALL, 8'h10); put(8'h10, CALL, 8'h20); put(8'h11, RET, 8'h00);
        put(8'h20, LDI, 8'h07);  put(8'h21, RET, 8'h00);
        release_rst();
        wait_halt();
        chk("t4_pc",    32'(bus.pc_out), 1);
        chk("t4_ac",    32'(ac_out), 7);
        chk("t4_fault", 32'(stack_fault), 0);

        // five nested CALLs overflow a 4-deep stack
        begin_test();
        put(8'h00, CALL, 8'h10); put(8'h10, CALL, 8'h20); put(8'h20, CALL, 8'h30);
        put(8'h30, CALL, 8'h40); put(8'h40, CALL, 8'h50);
        release_rst();
        wait_halt();
        chk("ovf_fault", 32'(stack_fault), 1);
        chk("ovf_pc",    32'(bus.pc_out), 'h40);
        begin_test();
        cycles(1);
        chk("rst_fault_clr", 32'(stack_fault), 0);

        // RET on empty stack
        put(8'h00, RET, 8'h00);
        release_rst();
        wait_halt();
        chk("unf_fault", 32'(stack_fault), 1);
        chk("unf_pc",    32'(bus.pc_out), 0);

        // PC wraps from FF to 00
        begin_test();
        put(8'h00, JMP, 8'hFF); put(8'hFF, NOP, 8'h00);
        release_rst();
        cycles(2);
        chk("wrap_jmp", 32'(bus.pc_out), 'hFF);
        cycles(2);
        chk("wrap_pc",  32'(bus.pc_out), 0);

        // illegal opcode halts and freezes the fetch address
        begin_test();
        put(8'h00, 8'h3C, 8'h00);
        release_rst();
        cycles(2);
        chk("ill_halted", 32'(halted), 1);
        cycles(4);
        chk("ill_pc",     32'(bus.pc_out), 0);
        chk("ill_req",    32'(bus.mem_req), 0);
        chk("ill_still",  32'(halted), 1);

        // reset asserted mid-MEM drops the request immediately
        begin_test();
        dmem[8'h40] = 8'h77;
        ack_lat = 20;
        put(8'h00, LD, 8'h40);
        release_rst();
        cycles(3);
        chk("mid_req",  32'(bus.mem_req), 1);
        chk("mid_addr", 32'(bus.mem_addr), 'h40);
        #2 res = 1'b0;
        #1;
        chk("abort_req",    32'(bus.mem_req), 0);
        chk("abort_addr",   32'(bus.mem_addr), 0);
        chk("abort_halted", 32'(halted), 0);
        chk("abort_pc",     32'(bus.pc_out), 0);
        ack_lat = 1;
        sb_push(1'b0, 8'h40, 8'h00);
        @(negedge clk);
        res = 1'b1;
        wait_halt();
        chk("resume_ac",    32'(ac_out), 'h77);
        chk("resume_pc",    32'(bus.pc_out), 1);
        chk("resume_drain", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
